// File: rtl/db_ctrl.sv
// rtl/db_ctrl.sv - ownership and sequencing controller for the shared packet data buffer
// Grants the buffer to one fill/drain pair at a time; all strobes are registered.
module db_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          store_host_data,
    input  logic          get_host_data,
    input  logic          store_rx_data,
    input  logic          get_tx_data,
    input  logic          rx_packet_done,
    input  logic          rx_error,
    input  logic          clear,
    output logic          write_en,
    output logic [AW-1:0] write_addr,
    output logic          read_en,
    output logic [AW-1:0] read_addr,
    output logic          wr_sel,
    output logic          rd_sel,
    output logic [6:0]    buffer_occupancy,
    output logic [2:0]    state_code,
    output logic          host_err,
    output logic          ovf_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HOST_FILL  = 3'd1,
        TX_DRAIN   = 3'd2,
        RX_FILL    = 3'd3,
        HOST_DRAIN = 3'd4
    } state_t;

    localparam logic [6:0] FULL = 7'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] wptr, wptr_nxt;
    logic [AW-1:0] rptr, rptr_nxt;
    logic [6:0]    occ, occ_nxt;
    logic          write_en_nxt, read_en_nxt;
    logic [AW-1:0] write_addr_nxt, read_addr_nxt;
    logic          wr_sel_nxt, rd_sel_nxt;
    logic          host_err_nxt, ovf_err_nxt;
    logic          do_write, do_read, flush;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            write_en   <= 1'b0;
            read_en    <= 1'b0;
            write_addr <= '0;
            read_addr  <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            host_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            wptr       <= wptr_nxt;
            rptr       <= rptr_nxt;
            occ        <= occ_nxt;
            write_en   <= write_en_nxt;
            read_en    <= read_en_nxt;
            write_addr <= write_addr_nxt;
            read_addr  <= read_addr_nxt;
            wr_sel     <= wr_sel_nxt;
            rd_sel     <= rd_sel_nxt;
            host_err   <= host_err_nxt;
            ovf_err    <= ovf_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        do_write       = 1'b0;
        do_read        = 1'b0;
        flush          = 1'b0;
        wr_sel_nxt     = wr_sel;
        rd_sel_nxt     = rd_sel;
        host_err_nxt   = 1'b0;
        ovf_err_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                host_err_nxt = get_host_data;
                if (store_rx_data) begin
                    state_nxt  = RX_FILL;
                    do_write   = 1'b1;
                    wr_sel_nxt = 1'b1;
                    if (store_host_data) host_err_nxt = 1'b1;
                end else if (store_host_data) begin
                    state_nxt  = HOST_FILL;
                    do_write   = 1'b1;
                    wr_sel_nxt = 1'b0;
                end
            end
            HOST_FILL: begin
                host_err_nxt = get_host_data;
                if (get_tx_data && occ != 7'd0) begin
                    state_nxt  = TX_DRAIN;
                    do_read    = 1'b1;
                    rd_sel_nxt = 1'b1;
                    if (store_host_data) host_err_nxt = 1'b1;
                end else if (store_host_data) begin
                    if (occ < FULL) do_write = 1'b1;
                    else            ovf_err_nxt = 1'b1;
                end
            end
            TX_DRAIN: begin
                host_err_nxt = store_host_data | get_host_data;
                if (get_tx_data && occ != 7'd0) begin
                    do_read    = 1'b1;
                    rd_sel_nxt = 1'b1;
                end
            end
            RX_FILL: begin
                host_err_nxt = store_host_data | get_host_data;
                if (rx_error) begin
                    state_nxt = IDLE;
                    flush     = 1'b1;
                end else if (rx_packet_done) begin
                    state_nxt = HOST_DRAIN;
                end else if (store_rx_data) begin
                    if (occ < FULL) begin
                        do_write   = 1'b1;
                        wr_sel_nxt = 1'b1;
                    end else begin
                        ovf_err_nxt = 1'b1;
                    end
                end
            end
            HOST_DRAIN: begin
                host_err_nxt = store_host_data;
                if (get_host_data) begin
                    if (occ != 7'd0) begin
                        do_read    = 1'b1;
                        rd_sel_nxt = 1'b0;
                    end else begin
                        host_err_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The last byte drained hands the buffer back with fresh pointers.
        if (do_read && occ == 7'd1) begin
            state_nxt = IDLE;
            flush     = 1'b1;
        end

        if (clear) begin
            state_nxt    = IDLE;
            flush        = 1'b1;
            do_write     = 1'b0;
            do_read      = 1'b0;
            wr_sel_nxt   = wr_sel;
            rd_sel_nxt   = rd_sel;
            host_err_nxt = 1'b0;
            ovf_err_nxt  = 1'b0;
        end

        write_en_nxt   = do_write;
        read_en_nxt    = do_read;
        write_addr_nxt = do_write ? wptr : write_addr;
        read_addr_nxt  = do_read  ? rptr : read_addr;

        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
            occ_nxt  = '0;
        end else begin
            wptr_nxt = do_write ? wptr + 1'b1 : wptr;
            rptr_nxt = do_read  ? rptr + 1'b1 : rptr;
            occ_nxt  = do_write ? occ + 7'd1 : (do_read ? occ - 7'd1 : occ);
        end
    end

    assign buffer_occupancy = occ;
    assign state_code       = state;

endmodule

// File: tb/tb_db_ctrl.sv
// tb/tb_db_ctrl.sv - directed self-checking bench for db_ctrl
module tb_db_ctrl;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       store_host_data, get_host_data, store_rx_data, get_tx_data;
    logic       rx_packet_done, rx_error, clear;
    logic       write_en, read_en, wr_sel, rd_sel, host_err, ovf_err;
    logic [5:0] write_addr, read_addr;
    logic [6:0] buffer_occupancy;
    logic [2:0] state_code;

    int n_cmp = 0;
    int n_bad = 0;

    db_ctrl #(.DEPTH(64), .AW(6)) dut (
        .clk(clk), .n_rst(n_rst),
        .store_host_data(store_host_data), .get_host_data(get_host_data),
        .store_rx_data(store_rx_data), .get_tx_data(get_tx_data),
        .rx_packet_done(rx_packet_done), .rx_error(rx_error), .clear(clear),
        .write_en(write_en), .write_addr(write_addr),
        .read_en(read_en), .read_addr(read_addr),
        .wr_sel(wr_sel), .rd_sel(rd_sel),
        .buffer_occupancy(buffer_occupancy), .state_code(state_code),
        .host_err(host_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sh, input logic gh, input logic sr, input logic gt,
                         input logic dn, input logic er, input logic cl);
        store_host_data = sh; get_host_data = gh; store_rx_data = sr; get_tx_data = gt;
        rx_packet_done  = dn; rx_error      = er; clear         = cl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},  write_en, 0);
        chk({tag, ".re"},  read_en, 0);
        chk({tag, ".occ"}, buffer_occupancy, 0);
        chk({tag, ".st"},  state_code, 0);
        chk({tag, ".he"},  host_err, 0);
        chk({tag, ".oe"},  ovf_err, 0);
        chk({tag, ".ws"},  wr_sel, 0);
        chk({tag, ".rs"},  rd_sel, 0);
    endtask

    initial begin
        n_rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk_zero("reset");
        n_rst = 1'b1;
        tick();

        // host fill then TX drain
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); tick();
            chk("hf.we", write_en, 1);
            chk("hf.wa", write_addr, i);
            chk("hf.occ", buffer_occupancy, i + 1);
            chk("hf.st", state_code, 1);
            chk("hf.ws", wr_sel, 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0); tick();
            chk("td.re", read_en, 1);
            chk("td.we", write_en, 0);
            chk("td.ra", read_addr, i);
            chk("td.occ", buffer_occupancy, 3 - i);
            chk("td.rs", rd_sel, 1);
            chk("td.st", state_code, (i < 3) ? 2 : 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("td.idle_re", read_en, 0);

        // RX fill then host drain
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0); tick();
            chk("rf.we", write_en, 1);
            chk("rf.wa", write_addr, i);
            chk("rf.ws", wr_sel, 1);
            chk("rf.st", state_code, 3);
            chk("rf.occ", buffer_occupancy, i + 1);
        end
        drive(0, 0, 0, 0, 1, 0, 0); tick();
        chk("done.st", state_code, 4);
        chk("done.we", write_en, 0);
        chk("done.occ", buffer_occupancy, 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0); tick();
            chk("hd.re", read_en, 1);
            chk("hd.ra", read_addr, i);
            chk("hd.rs", rd_sel, 0);
            chk("hd.occ", buffer_occupancy, 2 - i);
            chk("hd.st", state_code, (i < 2) ? 4 : 0);
            chk("hd.he", host_err, 0);
        end
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("idle_get.he", host_err, 1);
        chk("idle_get.re", read_en, 0);
        chk("idle_get.st", state_code, 0);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk("he_pulse", host_err, 0);

        // fill to full, 65th write overflows
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); tick();
            chk("full.we", write_en, 1);
            chk("full.wa", write_addr, i);
            chk("full.occ", buffer_occupancy, i + 1);
            chk("full.oe", ovf_err, 0);
        end
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("ovf.oe", ovf_err, 1);
        chk("ovf.we", write_en, 0);
        chk("ovf.occ", buffer_occupancy, 64);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        chk("clr.st", state_code, 0);
        chk("clr.occ", buffer_occupancy, 0);
        chk("clr.oe", ovf_err, 0);

        // simultaneous host/RX store in IDLE
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        chk("both.st", state_code, 3);
        chk("both.ws", wr_sel, 1);
        chk("both.wa", write_addr, 0);
        chk("both.we", write_en, 1);
        chk("both.he", host_err, 1);
        for (int i = 1; i < 10; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0); tick();
        end
        chk("rx10.occ", buffer_occupancy, 10);
        chk("rx10.wa", write_addr, 9);
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        chk("rxerr.st", state_code, 0);
        chk("rxerr.occ", buffer_occupancy, 0);
        chk("rxerr.we", write_en, 0);
        drive(0, 0, 1, 0, 0, 0, 0); tick();
        chk("rxerr2.wa", write_addr, 0);
        chk("rxerr2.we", write_en, 1);
        chk("rxerr2.st", state_code, 3);
        drive(0, 0, 0, 0, 0, 0, 1); tick();

        // clear during TX drain with a read request pending
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0); tick();
        chk("pre.st", state_code, 2);
        chk("pre.occ", buffer_occupancy, 5);
        drive(0, 0, 0, 1, 0, 0, 1); tick();
        chk("clrtx.re", read_en, 0);
        chk("clrtx.st", state_code, 0);
        chk("clrtx.occ", buffer_occupancy, 0);

        // async reset mid-fill
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0); tick();
        end
        chk("prerst.occ", buffer_occupancy, 3);
        #2;
        n_rst = 1'b0;
        #1;
        chk_zero("arst");
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("postrst.wa", write_addr, 0);
        chk("postrst.occ", buffer_occupancy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1);
    end
endmodule
